// File: rtl/alu_rs.sv
// Reservation station feeding the integer ALU: holds micro-ops until both operands
// are captured (at dispatch or from either CDB) and issues the lowest-indexed ready entry.
module alu_rs #(
  parameter int RS_SIZE_WIDTH  = 3,
  parameter int ROB_SIZE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic                      issue_valid,
  input  logic [4:0]                issue_op,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  input  logic [31:0]               issue_v1,
  input  logic [31:0]               issue_v2,
  input  logic                      issue_p1,
  input  logic                      issue_p2,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_q1,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_q2,
  input  logic                      alu_cdb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] alu_cdb_rob_id,
  input  logic [31:0]               alu_cdb_value,
  input  logic                      lsb_cdb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_cdb_rob_id,
  input  logic [31:0]               lsb_cdb_value,
  output logic                      full,
  output logic                      alu_valid,
  output logic [4:0]                alu_op,
  output logic [31:0]               alu_v1,
  output logic [31:0]               alu_v2,
  output logic [ROB_SIZE_WIDTH-1:0] alu_rob_id
);

  localparam int N  = 1 << RS_SIZE_WIDTH;
  localparam int RW = ROB_SIZE_WIDTH;

  typedef struct packed {
    logic          busy;
    logic [4:0]    op;
    logic [RW-1:0] rob;
    logic [31:0]   v1;
    logic          p1;
    logic [RW-1:0] q1;
    logic [31:0]   v2;
    logic          p2;
    logic [RW-1:0] q2;
  } entry_t;

  entry_t ent_q [N];
  entry_t ent_d [N];

  logic [N-1:0]             busy_vec;
  logic                     sel_found;
  logic [RS_SIZE_WIDTH-1:0] sel_idx;
  logic [RS_SIZE_WIDTH-1:0] free_idx;

  logic                     alu_valid_d;
  logic [4:0]               alu_op_d;
  logic [31:0]              alu_v1_d;
  logic [31:0]              alu_v2_d;
  logic [RW-1:0]            alu_rob_id_d;

  // Returns {pend, value}; the ALU CDB wins if both buses carry the same tag.
  function automatic logic [32:0] resolve(input logic p, input logic [RW-1:0] q,
                                          input logic [31:0] v);
    logic [32:0] r;
    r = {p, v};
    if (p) begin
      if (alu_cdb_valid && alu_cdb_rob_id == q)      r = {1'b0, alu_cdb_value};
      else if (lsb_cdb_valid && lsb_cdb_rob_id == q) r = {1'b0, lsb_cdb_value};
    end
    return r;
  endfunction

  always_comb begin
    busy_vec  = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      busy_vec[i] = ent_q[i].busy;
      if (ent_q[i].busy && !ent_q[i].p1 && !ent_q[i].p2) begin
        sel_found = 1'b1;
        sel_idx   = RS_SIZE_WIDTH'(i);
      end
      if (!ent_q[i].busy) free_idx = RS_SIZE_WIDTH'(i);
    end
  end

  assign full = &busy_vec;

  always_comb begin
    ent_d        = ent_q;
    alu_valid_d  = 1'b0;
    alu_op_d     = alu_op;
    alu_v1_d     = alu_v1;
    alu_v2_d     = alu_v2;
    alu_rob_id_d = alu_rob_id;

    for (int i = 0; i < N; i++) begin
      if (ent_q[i].busy) begin
        {ent_d[i].p1, ent_d[i].v1} = resolve(ent_q[i].p1, ent_q[i].q1, ent_q[i].v1);
        {ent_d[i].p2, ent_d[i].v2} = resolve(ent_q[i].p2, ent_q[i].q2, ent_q[i].v2);
      end
    end

    if (sel_found) begin
      ent_d[sel_idx].busy = 1'b0;
      alu_valid_d         = 1'b1;
      alu_op_d            = ent_q[sel_idx].op;
      alu_v1_d            = ent_q[sel_idx].v1;
      alu_v2_d            = ent_q[sel_idx].v2;
      alu_rob_id_d        = ent_q[sel_idx].rob;
    end

    // full comes from start-of-cycle state, so a slot freed by select is not reused here.
    if (issue_valid && !full) begin
      ent_d[free_idx].busy = 1'b1;
      ent_d[free_idx].op   = issue_op;
      ent_d[free_idx].rob  = issue_rob_id;
      ent_d[free_idx].q1   = issue_q1;
      ent_d[free_idx].q2   = issue_q2;
      {ent_d[free_idx].p1, ent_d[free_idx].v1} = resolve(issue_p1, issue_q1, issue_v1);
      {ent_d[free_idx].p2, ent_d[free_idx].v2} = resolve(issue_p2, issue_q2, issue_v2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) ent_q[i] <= '0;
      alu_valid  <= 1'b0;
      alu_op     <= '0;
      alu_v1     <= '0;
      alu_v2     <= '0;
      alu_rob_id <= '0;
    end else if (clear) begin
      for (int i = 0; i < N; i++) ent_q[i].busy <= 1'b0;
      alu_valid <= 1'b0;
    end else if (rdy) begin
      ent_q      <= ent_d;
      alu_valid  <= alu_valid_d;
      alu_op     <= alu_op_d;
      alu_v1     <= alu_v1_d;
      alu_v2     <= alu_v2_d;
      alu_rob_id <= alu_rob_id_d;
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: directed scenarios followed by random traffic,
// checked against a slot-level behavioural model of the station.
module tb_alu_rs;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, issue_valid;
  logic [4:0]  issue_op;
  logic [3:0]  issue_rob_id, issue_q1, issue_q2;
  logic [31:0] issue_v1, issue_v2;
  logic        issue_p1, issue_p2;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_rob_id, lsb_cdb_rob_id;
  logic [31:0] alu_cdb_value, lsb_cdb_value;
  logic        full, alu_valid;
  logic [4:0]  alu_op;
  logic [31:0] alu_v1, alu_v2;
  logic [3:0]  alu_rob_id;

  alu_rs #(.RS_SIZE_WIDTH(3), .ROB_SIZE_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rob_id(issue_rob_id),
    .issue_v1(issue_v1), .issue_v2(issue_v2), .issue_p1(issue_p1), .issue_p2(issue_p2),
    .issue_q1(issue_q1), .issue_q2(issue_q2),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_value(alu_cdb_value),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_value(lsb_cdb_value),
    .full(full), .alu_valid(alu_valid), .alu_op(alu_op), .alu_v1(alu_v1), .alu_v2(alu_v2),
    .alu_rob_id(alu_rob_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: eight slots, one dispatch record pushed per modelled ALU-valid cycle.
  typedef struct {
    bit       busy;
    bit [4:0] op;
    bit [3:0] rob;
    bit [31:0] v1, v2;
    bit       p1, p2;
    bit [3:0] q1, q2;
  } slot_t;

  typedef struct {
    bit [4:0]  op;
    bit [31:0] v1, v2;
    bit [3:0]  rob;
    int        cyc;
  } exp_t;

  slot_t     m [8];
  exp_t      sbq [$];
  bit        m_valid;
  bit [4:0]  m_op;
  bit [31:0] m_v1, m_v2;
  bit [3:0]  m_rob;

  function automatic bit [32:0] operand(bit pend, bit [3:0] tag, bit [31:0] val);
    if (!pend) return {1'b0, val};
    if (alu_cdb_valid && alu_cdb_rob_id == tag) return {1'b0, alu_cdb_value};
    if (lsb_cdb_valid && lsb_cdb_rob_id == tag) return {1'b0, lsb_cdb_value};
    return {1'b1, val};
  endfunction

  function automatic bit model_full();
    foreach (m[i]) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.op = m_op; e.v1 = m_v1; e.v2 = m_v2; e.rob = m_rob; e.cyc = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic model_edge();
    int sel = -1;
    int fr  = -1;
    bit [32:0] r;
    if (rst) begin
      foreach (m[i]) m[i] = '{default: 0};
      m_valid = 0; m_op = 0; m_v1 = 0; m_v2 = 0; m_rob = 0;
    end else if (clear) begin
      foreach (m[i]) m[i].busy = 0;
      m_valid = 0;
    end else if (!rdy) begin
      if (m_valid) push_exp();
    end else begin
      foreach (m[i]) begin
        if (sel < 0 && m[i].busy && !m[i].p1 && !m[i].p2) sel = i;
        if (fr < 0 && !m[i].busy) fr = i;
      end
      m_valid = (sel >= 0);
      if (m_valid) begin
        m_op = m[sel].op; m_v1 = m[sel].v1; m_v2 = m[sel].v2; m_rob = m[sel].rob;
        m[sel].busy = 0;
        push_exp();
      end
      foreach (m[i]) if (m[i].busy) begin
        r = operand(m[i].p1, m[i].q1, m[i].v1); m[i].p1 = r[32]; m[i].v1 = r[31:0];
        r = operand(m[i].p2, m[i].q2, m[i].v2); m[i].p2 = r[32]; m[i].v2 = r[31:0];
      end
      if (issue_valid && fr >= 0) begin
        m[fr].busy = 1; m[fr].op = issue_op; m[fr].rob = issue_rob_id;
        m[fr].q1 = issue_q1; m[fr].q2 = issue_q2;
        r = operand(issue_p1, issue_q1, issue_v1); m[fr].p1 = r[32]; m[fr].v1 = r[31:0];
        r = operand(issue_p2, issue_q2, issue_v2); m[fr].p2 = r[32]; m[fr].v2 = r[31:0];
      end
    end
  endtask

  // Monitor: every DUT dispatch must match the oldest expected record, including its cycle.
  always @(negedge clk) begin
    if (alu_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_dispatch: got rob %0d want none (cycle %0d)", alu_rob_id, cyc);
      end else begin
        automatic exp_t e = sbq.pop_front();
        chk("disp_op",    64'(alu_op),     64'(e.op));
        chk("disp_v1",    64'(alu_v1),     64'(e.v1));
        chk("disp_v2",    64'(alu_v2),     64'(e.v2));
        chk("disp_rob",   64'(alu_rob_id), 64'(e.rob));
        chk("disp_cycle", 64'(cyc),        64'(e.cyc));
      end
    end
  end

  task automatic idle();
    issue_valid = 0; alu_cdb_valid = 0; lsb_cdb_valid = 0; clear = 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("full", 64'(full), 64'(model_full()));
    idle();
  endtask

  task automatic issue(input bit [4:0] op, input bit [3:0] rob,
                       input bit [31:0] v1, input bit p1, input bit [3:0] q1,
                       input bit [31:0] v2, input bit p2, input bit [3:0] q2);
    issue_valid = 1; issue_op = op; issue_rob_id = rob;
    issue_v1 = v1; issue_p1 = p1; issue_q1 = q1;
    issue_v2 = v2; issue_p2 = p2; issue_q2 = q2;
  endtask

  task automatic acdb(input bit [3:0] tag, input bit [31:0] val);
    alu_cdb_valid = 1; alu_cdb_rob_id = tag; alu_cdb_value = val;
  endtask

  task automatic lcdb(input bit [3:0] tag, input bit [31:0] val);
    lsb_cdb_valid = 1; lsb_cdb_rob_id = tag; lsb_cdb_value = val;
  endtask

  initial begin
    rst = 1; rdy = 1; idle();
    issue(0, 0, 0, 0, 0, 0, 0, 0); issue_valid = 0;
    acdb(0, 0); lcdb(0, 0); alu_cdb_valid = 0; lsb_cdb_valid = 0;

    step(); step();
    rst = 0;
    chk("rst_valid", 64'(alu_valid), 64'(0));
    chk("rst_op",    64'(alu_op),    64'(0));
    chk("rst_v1",    64'(alu_v1),    64'(0));
    chk("rst_v2",    64'(alu_v2),    64'(0));
    chk("rst_rob",   64'(alu_rob_id), 64'(0));

    // ready at issue: alu_valid two cycles after the issue cycle
    issue(5'b00000, 2, 3, 0, 0, 4, 0, 0);
    step();
    chk("rai_early", 64'(alu_valid), 64'(0));
    step();
    chk("rai_valid", 64'(alu_valid), 64'(1));
    chk("rai_sum",   64'(alu_v1 + alu_v2), 64'(7));
    step();

    // wakeup through the ALU CDB
    issue(5'b01000, 3, 0, 1, 5, 1, 0, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("wake_hold", 64'(alu_valid), 64'(0));
    end
    acdb(5, 32'h10);
    step();
    chk("wake_k1", 64'(alu_valid), 64'(0));
    step();
    chk("wake_valid", 64'(alu_valid), 64'(1));
    chk("wake_v1",    64'(alu_v1),    64'(32'h10));
    chk("wake_v2",    64'(alu_v2),    64'(1));
    step();

    // issue-time bypass from the LSB CDB
    issue(5'b00000, 6, 5, 0, 0, 0, 1, 7);
    lcdb(7, 32'hFFFF_FFFF);
    step(); step();
    chk("byp_valid", 64'(alu_valid), 64'(1));
    chk("byp_v2",    64'(alu_v2),    64'(32'hFFFF_FFFF));
    step();

    // fill all eight slots, drop a ninth, free one
    for (int i = 1; i <= 8; i++) begin
      issue(5'b00000, 4'(i), 0, 1, 4'(i), 32'(i * 16), 0, 0);
      step();
    end
    chk("full_set", 64'(full), 64'(1));
    issue(5'b00000, 9, 1, 0, 0, 1, 0, 0);
    step();
    chk("full_drop", 64'(full), 64'(1));
    acdb(4, 32'h44);
    step();
    chk("full_k1", 64'(full), 64'(1));
    step();
    chk("free_full", 64'(full), 64'(0));
    chk("free_rob",  64'(alu_rob_id), 64'(4));
    chk("free_v1",   64'(alu_v1), 64'(32'h44));
    clear = 1;
    step();
    chk("clr_full", 64'(full), 64'(0));

    // entries 1 and 4 become ready together
    for (int i = 1; i <= 5; i++) begin
      issue(5'b10001, 4'(i), 0, 1, 4'(i), 32'(i), 0, 0);
      step();
    end
    acdb(2, 32'h222); lcdb(5, 32'h555);
    step(); step();
    chk("pri_first_v",   64'(alu_valid),  64'(1));
    chk("pri_first_rob", 64'(alu_rob_id), 64'(2));
    step();
    chk("pri_second_v",   64'(alu_valid),  64'(1));
    chk("pri_second_rob", 64'(alu_rob_id), 64'(5));

    // flush with five busy entries and a simultaneous issue
    issue(5'b00000, 6, 0, 1, 6, 0, 0, 0); step();
    issue(5'b00000, 7, 0, 1, 7, 0, 0, 0); step();
    clear = 1;
    issue(5'b00000, 11, 1, 0, 0, 2, 0, 0);
    acdb(1, 32'h1);
    step();
    chk("flush_full",  64'(full), 64'(0));
    chk("flush_valid", 64'(alu_valid), 64'(0));
    for (int t = 1; t <= 8; t++) begin
      acdb(4'(t), 32'(t));
      step();
      chk("flush_quiet", 64'(alu_valid), 64'(0));
    end

    // stall: everything holds while rdy is low
    issue(5'b00111, 12, 32'hAA, 0, 0, 32'h55, 0, 0);
    step(); step();
    chk("stall_pre", 64'(alu_valid), 64'(1));
    for (int k = 0; k < 3; k++) begin
      rdy = 0;
      issue(5'b00000, 13, 9, 0, 0, 9, 0, 0);
      acdb(3, 32'h33);
      step();
      chk("stall_valid", 64'(alu_valid),  64'(1));
      chk("stall_rob",   64'(alu_rob_id), 64'(12));
      chk("stall_v1",    64'(alu_v1),     64'(32'hAA));
      chk("stall_op",    64'(alu_op),     64'(5'b00111));
    end
    rdy = 1;
    step(); step();

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      rdy   = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 1) == 1)
        issue(5'($urandom), 4'($urandom), $urandom, 1'($urandom), 4'($urandom),
              $urandom, 1'($urandom), 4'($urandom));
      if ($urandom_range(0, 1) == 1) acdb(4'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) lcdb(4'($urandom), $urandom);
      step();
    end
    rdy = 1;
    step(); step(); step();
    chk("sb_drained", 64'(sbq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station that schedules the integer ALU in the out-of-order core. It accepts decoded ALU and branch-compare micro-ops from dispatch and holds them until both operands are available. Operands arrive either at dispatch or by snooping the two common data buses (ALU CDB, LSB CDB). Each cycle it sends at most one ready entry to the ALU, choosing the lowest-indexed ready entry.

## Interface
- RS_SIZE_WIDTH, 3: log2 of entry count (8 entries)
- ROB_SIZE_WIDTH, 4: ROB tag width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, all state and outputs hold
- clear  in  1  ROB flush (mispredict); synchronous
- issue_valid  in  1  dispatch writes one micro-op this cycle
- issue_op  in  5  ALU op encoding (bit4 = branch compare, bit3 = sub/sra, [2:0] = funct3)
- issue_rob_id  in  ROB_SIZE_WIDTH  destination ROB tag
- issue_v1, issue_v2  in  32  operand values (valid when the matching pend bit is 0)
- issue_p1, issue_p2  in  1  operand pending
- issue_q1, issue_q2  in  ROB_SIZE_WIDTH  producer tag of the pending operand
- alu_cdb_valid  in  1;  alu_cdb_rob_id  in  ROB_SIZE_WIDTH;  alu_cdb_value  in  32
- lsb_cdb_valid  in  1;  lsb_cdb_rob_id  in  ROB_SIZE_WIDTH;  lsb_cdb_value  in  32
- full  out  1  all entries busy (combinational from registered state)
- alu_valid  out  1  registered; qualifies the ALU inputs this cycle
- alu_op  out  5;  alu_v1, alu_v2  out  32;  alu_rob_id  out  ROB_SIZE_WIDTH  registered ALU inputs

## Operation
- Each entry holds busy, op, rob_id, v1, p1, q1, v2, p2, q2.
- Insert
  - If issue_valid && !full, the op is written into the lowest-index non-busy entry at the clock edge.
  - If issue_valid is asserted while full, the op is dropped and no state changes. This is a dispatch contract violation.
  - full is computed from start-of-cycle state. An entry freed by this cycle's selection cannot accept this cycle's issue.
- Wakeup
  - Applies to every busy entry with p1 or p2 set. If the pending tag equals a valid CDB tag, capture the CDB value and clear the pend bit at the edge.
  - Both operands may wake in the same cycle, including when q1 == q2.
  - If both CDBs match the same tag, alu_cdb has priority. Unique ROB tags make this unreachable in normal operation.
- Issue-time bypass: an incoming pending operand whose tag matches a CDB valid in the same cycle is written with the CDB value and its pend bit cleared.
- Select
  - An entry is ready when busy && !p1 && !p2, judged on start-of-cycle state.
  - The lowest-index ready entry is chosen. At the edge its fields are copied to alu_op, alu_v1, alu_v2 and alu_rob_id, alu_valid is set to 1, and busy is cleared.
  - If no entry is ready, alu_valid goes to 0. The other alu_* outputs hold their last values.
- Priority at a clock edge: rst > clear > (!rdy hold) > normal update.
  - clear: all busy bits go to 0 and alu_valid to 0. Issue and wakeup in that cycle are discarded.
  - rdy low: nothing changes, including alu_valid. CDB broadcasts presented while rdy is low are ignored.
- The ALU latches its inputs every cycle. Consumers of the ALU result must qualify it with the alu_valid value delayed by one cycle.

## Timing
- Reset values: all busy = 0, full = 0, alu_valid = 0, alu_op = 0, alu_v1 = 0, alu_v2 = 0, alu_rob_id = 0.
- Issue with both operands ready in cycle 0:
  - entry busy in cycle 1, selected in cycle 1
  - alu_valid = 1 in cycle 2
  - ALU result registered in cycle 3
- Wakeup via CDB in cycle k: entry ready in cycle k+1, alu_valid in cycle k+2. Issue-time bypass gives the same latency as ready-at-issue.
- Throughput: one dispatch to the ALU per cycle. Back-to-back ready entries produce consecutive alu_valid cycles.
- full deasserts in the cycle after the select edge that frees an entry.
- After rst or clear, entries are empty and alu_valid = 0 from the next cycle.

## Test plan
- Ready-at-issue: after reset, issue op = 5'b00000, v1 = 3, v2 = 4, rob_id = 2 in cycle 0. Expect alu_valid = 1 in cycle 2 with v1 = 3, v2 = 4, rob_id = 2, and the ALU result 7 in cycle 3.
- Wakeup: issue op = sub with p1 = 1, q1 = 5, v2 = 1 and hold for 3 cycles. Expect no alu_valid. Then alu_cdb broadcasts (5, 0x10). Expect alu_valid two cycles later with alu_v1 = 0x10 and alu_v2 = 1.
- Bypass: issue with p2 = 1, q2 = 7 while lsb_cdb broadcasts (7, 0xFFFFFFFF) in the same cycle. Expect dispatch two cycles later with alu_v2 = 0xFFFFFFFF.
- Full / backpressure:
  - Issue 8 ops with pending q1 = 1..8. Expect full = 1.
  - A 9th issue with rob_id = 9 is dropped.
  - Broadcast tag 4: the entry with rob_id 4 dispatches and full = 0 in the cycle after its select edge.
  - Expect rob_id 9 never to appear.
- Priority: make entries 1 and 4 ready in the same cycle. Expect entry 1 dispatched first, entry 4 in the next cycle, and two consecutive alu_valid cycles.
- Flush and stall:
  - With 5 busy entries, assert clear together with issue_valid. Next cycle: full = 0 and alu_valid = 0, and nothing dispatches afterwards.
  - Separately, drop rdy for 3 cycles while alu_valid = 1. Expect all outputs to hold unchanged.
